irq_collector: RTL and testbench

//  Interrupt aggregation stage directly downstream of the timer peripherals.

---
 rtl/irq_collector.sv | 127 ++++++++++++
 tb/tb_irq_collector.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/irq_collector.sv
// irq_collector: interrupt aggregation stage between the timers / external
// source and CP0. Synchronises the raw lines, latches them into a pending
// register (per-source edge or level capture), masks them onto HWInt and
// exposes PEND/MASK/MODE/OVF/CAUSE/RAW on the bridge slave interface.
module irq_collector #(
    parameter int unsigned N_SRC = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:2]      Addr,
    input  logic             WE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    input  logic [N_SRC-1:0] irq_in,
    output logic [5:0]       HWInt
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 3;

    localparam logic [2:0] REG_PEND  = 3'd0;
    localparam logic [2:0] REG_MASK  = 3'd1;
    localparam logic [2:0] REG_MODE  = 3'd2;
    localparam logic [2:0] REG_OVF   = 3'd3;
    localparam logic [2:0] REG_CAUSE = 3'd4;
    localparam logic [2:0] REG_RAW   = 3'd5;

    logic [N_SRC-1:0] s1_q, s2_q;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] ovf_q, ovf_d;

    logic [2:0]       reg_sel;
    logic [N_SRC-1:0] wr_data;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pend_w1c;
    logic [N_SRC-1:0] ovf_w1c;
    logic [N_SRC-1:0] pend_kept;
    logic [N_SRC-1:0] mode_chg;
    logic [N_SRC-1:0] active;
    logic             cause_valid;
    logic [IDX_W-1:0] cause_idx;

    // Only the word index within the block is decoded; the bridge does chip select.
    assign reg_sel = Addr[4:2];
    assign wr_data = Din[N_SRC-1:0];

    logic unused_bits;
    assign unused_bits = ^{Addr[31:5], Din[31:N_SRC]};

    // Next-state for pending, overflow, mask and mode registers.
    always_comb begin
        pend_w1c  = '0;
        ovf_w1c   = '0;
        mode_chg  = '0;
        mask_d    = mask_q;
        mode_d    = mode_q;
        rise      = s1_q & ~s2_q;

        if (WE && reg_sel == REG_PEND) pend_w1c = wr_data;
        if (WE && reg_sel == REG_OVF)  ovf_w1c  = wr_data;
        if (WE && reg_sel == REG_MASK) mask_d   = wr_data;
        if (WE && reg_sel == REG_MODE) begin
            mode_d   = wr_data;
            mode_chg = wr_data ^ mode_q;
        end

        // A rise that lands on the same edge as W1C wins and is not an overflow.
        pend_kept = pend_q & ~pend_w1c;
        pend_d    = (mode_q & (pend_kept | rise)) | (~mode_q & s1_q);
        ovf_d     = (ovf_q & ~ovf_w1c) | (mode_q & rise & pend_kept);

        // Switching a source's capture mode discards its history.
        pend_d = pend_d & ~mode_chg;
        ovf_d  = ovf_d & ~mode_chg;
    end

    // State registers, including the two-flop input synchroniser.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            pend_q <= '0;
            mask_q <= '0;
            mode_q <= '0;
            ovf_q  <= '0;
        end else begin
            s1_q   <= irq_in;
            s2_q   <= s1_q;
            pend_q <= pend_d;
            mask_q <= mask_d;
            mode_q <= mode_d;
            ovf_q  <= ovf_d;
        end
    end

    // Lowest-numbered pending and enabled source for CAUSE.
    always_comb begin
        active      = pend_q & mask_q;
        cause_valid = 1'b0;
        cause_idx   = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (active[i] && !cause_valid) begin
                cause_valid = 1'b1;
                cause_idx   = IDX_W'(i);
            end
        end
    end

    assign HWInt = 6'(pend_q & mask_q);

    // Combinational read mux.
    always_comb begin
        Dout = '0;
        case (reg_sel)
            REG_PEND:  Dout = DATA_W'(pend_q);
            REG_MASK:  Dout = DATA_W'(mask_q);
            REG_MODE:  Dout = DATA_W'(mode_q);
            REG_OVF:   Dout = DATA_W'(ovf_q);
            REG_CAUSE: Dout = {cause_valid, 28'd0, cause_idx};
            REG_RAW:   Dout = DATA_W'(s1_q);
            default:   Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_collector.sv
// Directed table-driven bench for irq_collector (N_SRC = 3).
// Each table row is one clock cycle: inputs are driven after the falling
// edge, outputs are compared shortly after, and the row's inputs are then
// captured by the following rising edge.
module tb_irq_collector;

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [2:0]  irq_in;
    logic [5:0]  HWInt;

    irq_collector #(.N_SRC(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .Addr   (Addr),
        .WE     (WE),
        .Din    (Din),
        .Dout   (Dout),
        .irq_in (irq_in),
        .HWInt  (HWInt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [2:0]  a;
        logic [31:0] din;
        logic [2:0]  irq;
        logic [5:0]  exp_hw;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(logic rst, logic we, logic [2:0] a, logic [31:0] din,
                                logic [2:0] irq, logic [5:0] hw, logic [31:0] dout);
        vec_t v;
        v.rst = rst; v.we = we; v.a = a; v.din = din; v.irq = irq;
        v.exp_hw = hw; v.exp_dout = dout;
        tbl.push_back(v);
    endfunction

    task automatic drive(logic r, logic w, logic [2:0] a, logic [31:0] d, logic [2:0] irq);
        reset  = r;
        WE     = w;
        Addr   = {27'h2ABCDEF, a};
        Din    = d;
        irq_in = irq;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;

        // Test 1: level mode pulse on bit1, two-cycle latency, one cycle wide.
        add(0,1,1,32'd7,3'b000,6'd0,32'd0);
        add(0,0,1,32'd0,3'b000,6'd0,32'd7);
        add(0,0,2,32'd0,3'b010,6'd0,32'd0);
        add(0,0,5,32'd0,3'b000,6'd0,32'd2);
        add(0,0,4,32'd0,3'b000,6'd2,32'h8000_0001);
        add(0,0,4,32'd0,3'b000,6'd0,32'd0);
        // Test 2: edge mode on bit0, two pulses -> overflow, then W1C both.
        add(0,1,2,32'd1,3'b000,6'd0,32'd0);
        add(0,0,2,32'd0,3'b001,6'd0,32'd1);
        add(0,0,0,32'd0,3'b000,6'd0,32'd0);
        add(0,0,0,32'd0,3'b001,6'd1,32'd1);
        add(0,0,3,32'd0,3'b000,6'd1,32'd0);
        add(0,0,3,32'd0,3'b000,6'd1,32'd1);
        add(0,1,0,32'd1,3'b000,6'd1,32'd1);
        add(0,1,3,32'd1,3'b000,6'd0,32'd1);
        // Test 3: W1C of PEND[0] coinciding with a rise on bit0.
        add(0,0,3,32'd0,3'b001,6'd0,32'd0);
        add(0,0,0,32'd0,3'b000,6'd0,32'd0);
        add(0,0,0,32'd0,3'b001,6'd1,32'd1);
        add(0,1,0,32'd1,3'b000,6'd1,32'd1);
        add(0,0,0,32'd0,3'b000,6'd1,32'd1);
        add(0,0,3,32'd0,3'b000,6'd1,32'd0);
        add(0,1,0,32'd7,3'b000,6'd1,32'd1);
        // Test 4: masked source still pends; unmasking exposes it; CAUSE priority.
        add(0,1,1,32'd0,3'b000,6'd0,32'd7);
        add(0,1,2,32'd3,3'b000,6'd0,32'd1);
        add(0,0,2,32'd0,3'b010,6'd0,32'd3);
        add(0,0,0,32'd0,3'b000,6'd0,32'd0);
        add(0,0,0,32'd0,3'b000,6'd0,32'd2);
        add(0,1,1,32'd2,3'b000,6'd0,32'd0);
        add(0,0,4,32'd0,3'b101,6'd2,32'h8000_0001);
        add(0,1,1,32'd7,3'b101,6'd2,32'd2);
        add(0,0,4,32'd0,3'b000,6'd7,32'h8000_0000);
        add(0,0,0,32'd0,3'b000,6'd7,32'd7);
        add(0,0,0,32'd0,3'b000,6'd3,32'd3);
        // Test 5: changing bit0 to level clears it, then it follows the input.
        add(0,1,2,32'd2,3'b000,6'd3,32'd3);
        add(0,0,0,32'd0,3'b001,6'd2,32'd2);
        add(0,0,0,32'd0,3'b001,6'd2,32'd2);
        add(0,0,0,32'd0,3'b000,6'd3,32'd3);
        add(0,0,0,32'd0,3'b000,6'd3,32'd3);
        // Writes to read-only / unused addresses and upper data bits are ignored.
        add(0,1,4,32'hFFFF_FFFF,3'b000,6'd2,32'h8000_0001);
        add(0,1,6,32'hFFFF_FFFF,3'b000,6'd2,32'd0);
        add(0,1,7,32'hFFFF_FFFF,3'b000,6'd2,32'd0);
        add(0,1,1,32'hFFFF_FFFA,3'b000,6'd2,32'd7);
        add(0,0,1,32'd0,3'b000,6'd2,32'd2);
        // Reset in the middle of operation with PEND=7, MASK=7 and a write pending.
        add(0,1,2,32'd0,3'b111,6'd2,32'd2);
        add(0,1,1,32'd7,3'b111,6'd0,32'd2);
        add(0,0,0,32'd0,3'b111,6'd7,32'd7);
        add(1,1,1,32'd7,3'b111,6'd7,32'd7);
        add(0,0,6,32'd0,3'b111,6'd0,32'd0);
        add(0,0,5,32'd0,3'b000,6'd0,32'd7);
        add(0,0,0,32'd0,3'b000,6'd0,32'd7);
        add(0,0,7,32'd0,3'b000,6'd0,32'd0);
        add(0,0,1,32'd0,3'b000,6'd0,32'd0);

        drive(1, 0, 3'd0, 32'd0, 3'b000);
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].we, tbl[i].a, tbl[i].din, tbl[i].irq);
            #1;
            check($sformatf("row%0d_hwint", i), 32'(HWInt), 32'(tbl[i].exp_hw));
            check($sformatf("row%0d_dout", i), Dout, tbl[i].exp_dout);
        end

        // Latency of a one-cycle level pulse on bit2 with only bit2 enabled.
        @(negedge clk);
        drive(0, 1, 3'd1, 32'd4, 3'b000);
        @(negedge clk);
        drive(0, 0, 3'd4, 32'd0, 3'b100);
        @(negedge clk);
        drive(0, 0, 3'd4, 32'd0, 3'b000);
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (HWInt[2]) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL lat_timeout: HWInt[2] never rose within 10 cycles, expected 2");
        end else begin
            check("lat_cycles", 32'(lat), 32'd2);
            check("lat_cause", Dout, 32'h8000_0002);
            check("lat_hwint", 32'(HWInt), 32'h4);
            @(negedge clk);
            #1;
            check("lat_width", 32'(HWInt), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
